// File: rtl/morse_pkg.sv
// Shared encodings, state type and timing multiples for the Morse transmit path.
package morse_pkg;

  // Two-bit element codes packed five to a symbol, first element in the MSBs
  localparam logic [1:0] EL_NONE = 2'b00;
  localparam logic [1:0] EL_DOT  = 2'b01;
  localparam logic [1:0] EL_DASH = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    CHAR_GAP,
    WORD_GAP
  } seq_state_e;

  // Durations in Morse units
  localparam logic [2:0] DOT_U      = 3'd1;
  localparam logic [2:0] DASH_U     = 3'd3;
  localparam logic [2:0] ELEM_GAP_U = 3'd1;
  localparam logic [2:0] CHAR_GAP_U = 3'd3;
  localparam logic [2:0] WORD_GAP_U = 3'd7;

  // 00 and 11 both terminate a symbol; only 01/10 key the output
  function automatic logic is_mark_el(input logic [1:0] el);
    return (el == EL_DOT) || (el == EL_DASH);
  endfunction

  function automatic logic [2:0] el_units(input logic [1:0] el);
    return (el == EL_DASH) ? DASH_U : DOT_U;
  endfunction

endpackage

// File: rtl/morse_sym_fifo.sv
// Small symbol FIFO: synchronous push/pop, synchronous clear, occupancy count.
module morse_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Clear drops any same-cycle push; pop only when something is stored
  assign do_push = push && (cnt_q < FULL_CNT) && !clear;
  assign do_pop  = pop && (cnt_q != '0) && !clear;

  // Pointer and occupancy next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage write port
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
  end

  // Control state, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage carries no reset; validity comes from the count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_q];
  assign count     = cnt_q;

endmodule

// File: rtl/morse_tx_sequencer.sv
// Morse keying sequencer: buffers 10-bit symbol codes and drives key_out with
// dot/dash/gap timing measured in units of UNIT_CYCLES clocks.
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [9:0]                  in_code,
  input  logic                        in_word_end,
  input  logic                        flush,
  output logic                        key_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       units_q, units_d;
  logic [9:0]       sr_q, sr_d;
  logic             word_q, word_d;
  logic             key_q, key_d;
  logic             fifo_push, fifo_pop;
  logic [10:0]      head;
  logic [2:0]       req_u;
  logic             unit_wrap, seg_done;

  // Ready looks only at stored entries, never at a same-cycle pop
  assign in_ready  = fifo_count < CW'(FIFO_DEPTH);
  assign fifo_push = in_valid && in_ready;

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (11)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ({in_word_end, in_code}),
    .head_data (head),
    .count     (fifo_count)
  );

  // Length of the current segment in units; the trailing gap replaces the
  // element gap rather than adding to it
  always_comb begin
    case (state_q)
      MARK:     req_u = el_units(sr_q[9:8]);
      SPACE:    req_u = ELEM_GAP_U;
      CHAR_GAP: req_u = CHAR_GAP_U;
      WORD_GAP: req_u = WORD_GAP_U;
      default:  req_u = 3'd1;
    endcase
  end

  assign unit_wrap = (cnt_q == CNT_LAST);
  assign seg_done  = unit_wrap && (units_q == (req_u - 3'd1));

  // Sequencer next state: pop in IDLE, time marks and gaps elsewhere
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    units_d  = units_q;
    sr_d     = sr_q;
    word_d   = word_q;
    fifo_pop = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      units_d = '0;
      sr_d    = '0;
      word_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_count != '0) begin
            fifo_pop = 1'b1;
            sr_d     = head[9:0];
            word_d   = head[10];
            if (is_mark_el(head[9:8])) begin
              state_d = MARK;
            end else if (head[10]) begin
              state_d = WORD_GAP;
            end
          end
        end
        default: begin
          if (unit_wrap) begin
            cnt_d   = '0;
            units_d = units_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (seg_done) begin
            cnt_d   = '0;
            units_d = '0;
            case (state_q)
              MARK: begin
                sr_d = {sr_q[7:0], EL_NONE};
                if (is_mark_el(sr_q[7:6])) begin
                  state_d = SPACE;
                end else if (word_q) begin
                  state_d = WORD_GAP;
                end else begin
                  state_d = CHAR_GAP;
                end
              end
              SPACE:   state_d = MARK;
              default: state_d = IDLE;
            endcase
          end
        end
      endcase
    end
    key_d = (state_d == MARK);
  end

  // Sequencer registers; key_out is a flop so it changes on the state edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      units_q <= '0;
      sr_q    <= '0;
      word_q  <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      key_q   <= key_d;
    end
  end

  assign key_out = key_q;
  assign busy    = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Bench for morse_tx_sequencer: symbol-level timeline model feeding a pulse
// scoreboard, plus directed flush and asynchronous reset scenarios.
module tb_morse_tx_sequencer;

  localparam int UC    = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] in_code = '0;
  logic       in_word_end = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, key_out, busy;
  logic [2:0] fifo_count;

  morse_tx_sequencer #(
    .UNIT_CYCLES (UC),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .in_word_end (in_word_end),
    .flush       (flush),
    .key_out     (key_out),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // edge_n-1 is the index of the most recent rising edge
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n - 1);
    end
  endfunction

  // Reference model: one entry per accepted symbol (accept edge, pop edge,
  // edge at which the sequencer is idle again) and the expected mark pulses
  int     ma[$];
  int     mp[$];
  int     mf[$];
  pulse_t exp_q[$];
  int     last_free = -1000;
  bit     sb_on = 1'b0;
  bit     in_pulse = 1'b0;
  bit     key_prev = 1'b0;
  int     rise_e = 0;
  pulse_t cur_p;

  function automatic void model_clear();
    ma.delete();
    mp.delete();
    mf.delete();
    exp_q.delete();
    last_free = -1000;
    in_pulse  = 1'b0;
  endfunction

  function automatic int model_count(int e);
    int c = 0;
    foreach (ma[i]) if (ma[i] <= e && mp[i] > e) c++;
    return c;
  endfunction

  function automatic bit model_busy(int e);
    foreach (ma[i]) if (ma[i] <= e && e < mf[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_accept(int a, logic [9:0] code, logic we);
    int p, t, nm, u, fr;
    logic [1:0] el;
    logic [9:0] c;
    pulse_t pl;
    p  = (a + 1 > last_free + 1) ? a + 1 : last_free + 1;
    t  = p;
    nm = 0;
    c  = code;
    for (int i = 0; i < 5; i++) begin
      el = c[9:8];
      c  = c << 2;
      if (el == 2'b01 || el == 2'b10) begin
        if (nm > 0) t += UC;
        u = (el == 2'b01) ? 1 : 3;
        pl.start = t;
        pl.len   = u * UC;
        exp_q.push_back(pl);
        t += u * UC;
        nm++;
      end else begin
        break;
      end
    end
    if (nm == 0) fr = we ? p + 7 * UC : p;
    else         fr = t + (we ? 7 : 3) * UC;
    ma.push_back(a);
    mp.push_back(p);
    mf.push_back(fr);
    last_free = fr;
  endfunction

  function automatic logic [9:0] rand_code();
    logic [9:0] c;
    int n;
    c = 10'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) c[9-2*i -: 2] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      if (n < 5) c[9-2*n -: 2] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    end
    return c;
  endfunction

  // Monitor: compares busy/fifo_count every cycle and each key pulse
  // against the head of the expected-pulse queue
  always @(negedge clk) begin
    int e;
    e = edge_n - 1;
    if (sb_on) begin
      chk("busy", int'(busy), int'(model_busy(e)));
      chk("fifo_count", int'(fifo_count), model_count(e));
      if (key_out && !key_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mark", 1, 0);
        end else begin
          cur_p = exp_q.pop_front();
          chk("mark_start", e, cur_p.start);
          rise_e   = e;
          in_pulse = 1'b1;
        end
      end else if (!key_out && key_prev && in_pulse) begin
        chk("mark_len", e - rise_e, cur_p.len);
        in_pulse = 1'b0;
      end
    end
    key_prev = key_out;
  end

  // Offer a symbol from the next falling edge until the model says it is
  // accepted; while the FIFO is full the payload wanders randomly
  task automatic offer(input logic [9:0] code, input logic we, output int acc_e);
    int e;
    bit rdy;
    acc_e = -1;
    for (int k = 0; k < 2000 && acc_e < 0; k++) begin
      @(negedge clk);
      e   = edge_n;
      rdy = model_count(e - 1) < DEPTH;
      chk("in_ready", int'(in_ready), int'(rdy));
      in_valid = 1'b1;
      if (rdy) begin
        in_code     = code;
        in_word_end = we;
        model_accept(e, code, we);
        acc_e = e;
      end else begin
        in_code     = 10'($urandom);
        in_word_end = 1'($urandom);
      end
    end
    if (acc_e < 0) chk("offer_timeout", 0, 1);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic at_edge(input int e);
    while (edge_n - 1 < e) @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (model_busy(edge_n - 1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("drain_busy", int'(busy), 0);
    chk("pending_pulses", exp_q.size(), 0);
    chk("open_pulse", int'(in_pulse), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, acc, nsent;
    #1 reset = 1'b0;
    #2;
    chk("rst_key", int'(key_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    sb_on = 1'b1;

    // "A": dot, dash, char gap
    offer(10'b0110000000, 1'b0, a);
    drop_valid();
    at_edge(a + 1);  chk("A_dot_on", int'(key_out), 1);
    at_edge(a + 4);  chk("A_dot_hold", int'(key_out), 1);
    at_edge(a + 5);  chk("A_dot_off", int'(key_out), 0);
    at_edge(a + 8);  chk("A_space", int'(key_out), 0);
    at_edge(a + 9);  chk("A_dash_on", int'(key_out), 1);
    at_edge(a + 20); chk("A_dash_hold", int'(key_out), 1);
    at_edge(a + 21); chk("A_dash_off", int'(key_out), 0);
    at_edge(a + 32); chk("A_busy_gap", int'(busy), 1);
    at_edge(a + 33); chk("A_busy_end", int'(busy), 0);
    drain();

    // "E" closing a word, then "T" back to back
    offer(10'b0100000000, 1'b1, a);
    offer(10'b1000000000, 1'b0, b);
    drop_valid();
    at_edge(a + 1);  chk("E_on", int'(key_out), 1);
    at_edge(a + 4);  chk("E_hold", int'(key_out), 1);
    at_edge(a + 5);  chk("E_off", int'(key_out), 0);
    at_edge(a + 33); chk("ET_idle", int'(key_out), 0);
    at_edge(a + 34); chk("T_on", int'(key_out), 1);
    at_edge(a + 45); chk("T_hold", int'(key_out), 1);
    at_edge(a + 46); chk("T_off", int'(key_out), 0);
    drain();

    // Empty codes: discarded, then a bare word gap
    offer(10'b0000000000, 1'b0, a);
    drop_valid();
    at_edge(a);     chk("empty_busy", int'(busy), 1);
    at_edge(a + 1); chk("empty_done", int'(busy), 0);
    offer(10'b1100000000, 1'b1, b);
    drop_valid();
    at_edge(b + 1);  chk("wgap_busy", int'(busy), 1);
    at_edge(b + 28); chk("wgap_hold", int'(busy), 1);
    at_edge(b + 28); chk("wgap_key", int'(key_out), 0);
    at_edge(b + 29); chk("wgap_end", int'(busy), 0);
    drain();

    // Fill the FIFO behind a long "0"
    offer(10'b1010101010, 1'b0, a);
    offer(10'b0100000000, 1'b0, b);
    offer(10'b1000000000, 1'b1, b);
    offer(10'b0101000000, 1'b0, b);
    offer(10'b1010000000, 1'b0, b);
    at_edge(a + 4);
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready", int'(in_ready), 0);
    offer(10'b1001000000, 1'b1, acc);
    drop_valid();
    chk("fifth_accept_edge", acc, a + 91);
    drain();

    // Flush during the dash of "A" with two symbols queued
    sb_on = 1'b0;
    model_clear();
    offer(10'b0110000000, 1'b0, a);
    offer(10'b0100000000, 1'b0, b);
    offer(10'b1000000000, 1'b0, b);
    drop_valid();
    at_edge(a + 12);
    chk("pre_flush_key", int'(key_out), 1);
    chk("pre_flush_count", int'(fifo_count), 2);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_code     = 10'b0100000000;
    in_word_end = 1'b0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_key", int'(key_out), 0);
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_ready", int'(in_ready), 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_flush_key", int'(key_out), 0);
      chk("post_flush_count", int'(fifo_count), 0);
    end
    model_clear();

    // Asynchronous reset in the middle of a mark
    offer(10'b1000000000, 1'b0, a);
    offer(10'b0100000000, 1'b0, b);
    drop_valid();
    at_edge(a + 3);
    chk("pre_rst_key", int'(key_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_key", int'(key_out), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_count", int'(fifo_count), 0);
    chk("async_rst_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_key", int'(key_out), 0);
    end
    chk("post_rst_count", int'(fifo_count), 0);
    chk("post_rst_ready", int'(in_ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    model_clear();
    sb_on = 1'b1;

    // Random symbols at random spacing, often overrunning the FIFO
    nsent = 0;
    for (int c = 0; c < 20000 && nsent < 40; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        offer(rand_code(), 1'($urandom), acc);
        nsent++;
      end else begin
        @(negedge clk);
        in_valid    = 1'b0;
        in_code     = 10'($urandom);
        in_word_end = 1'($urandom);
      end
    end
    drop_valid();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx_sequencer.md
Name: morse_tx_sequencer

Overview:
Transmit-side controller for the Morse path. It accepts 10-bit symbol codes in the same format the decoder produces on `saida`. It buffers them in a small FIFO and sequences a single keying output (LED/buzzer) with standard Morse timing: dot = 1 unit, dash = 3 units, element gap 1, character gap 3, word gap 7. It sits between the decoded-symbol register (echo) or a message source and the key output pin.

Parameters:
- UNIT_CYCLES, 12500000, clock cycles per Morse time unit (250 ms at 50 MHz); minimum 2.
- FIFO_DEPTH, 4, symbol FIFO entries; power of two, minimum 2.
- CNT_W, 24, width of the unit cycle counter; must hold UNIT_CYCLES-1.

Ports:
- clk, in, 1, system clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low reset (reset=0 clears everything immediately).
- in_valid, in, 1, symbol offered.
- in_ready, out, 1, FIFO can accept; equals (count < FIFO_DEPTH).
- in_code, in, 10, symbol code (format below).
- in_word_end, in, 1, symbol closes a word; use the word gap after it.
- flush, in, 1, synchronous abort: drop queued and in-flight symbols.
- key_out, out, 1, registered keying output; 1 = mark.
- busy, out, 1, (state != IDLE) or (count != 0).
- fifo_count, out, $clog2(FIFO_DEPTH)+1, entries stored.

Behaviour:
- Code format: 5 elements, 2 bits each, first element in [9:8], last in [1:0].
  - 01 = dot, 10 = dash.
  - 00 or 11 = terminator; elements after the first terminator are ignored.
- Push: a symbol is accepted on an edge where in_valid && in_ready. Each FIFO entry stores {in_word_end, in_code}.
- Push and pop may occur on the same edge. in_ready does not consider the same-cycle pop.
- Reset (reset=0, async), all outputs: key_out=0, busy=0, fifo_count=0, in_ready=1, state=IDLE, counters=0.
- States: IDLE, MARK, SPACE, CHAR_GAP, WORD_GAP.
- IDLE: if count != 0, pop the head into the element shift register and the word flag on that edge.
  - First element dot/dash: go to MARK and set key_out=1 on that same edge. Push at edge N, idle sequencer, empty FIFO means key_out=1 after edge N+1.
  - First element is a terminator (empty code) and word flag=1: go to WORD_GAP, key_out=0.
  - Empty code and word flag=0: discard and stay IDLE (one-cycle pop).
- MARK: held for 1 unit (dot) or 3 units (dash); units = k*UNIT_CYCLES cycles, where k is the element's unit multiple. On expiry key_out=0, shift to the next element, then:
  - next element valid: go to SPACE (1 unit), then back to MARK with key_out=1.
  - no further element: go to WORD_GAP (7 units) if word flag, else CHAR_GAP (3 units).
- Gaps are not additive: the gap after the last element is 3 or 7 units total, not 1+3.
- CHAR_GAP / WORD_GAP expiry: go to IDLE. The next pop may happen on the cycle after expiry (one idle cycle between symbols).
- Unit counter: reloads 0 at every state entry and counts to UNIT_CYCLES-1. The unit counter (3 bits) increments on wrap. State exits when the unit count reaches the required multiple.
- key_out is 1 only in MARK.
- flush=1: on the next edge, FIFO empties, key_out=0, state=IDLE, counters=0. flush takes priority over a simultaneous push, which is dropped.
- Async reset mid-symbol: key_out drops immediately; no partial symbol resumes.
- Full FIFO: in_ready=0, in_valid is ignored, and in_code/in_word_end may change freely.

Decomposition:
- Package morse_pkg holds:
  - element encodings: EL_NONE=00, EL_DOT=01, EL_DASH=10.
  - state enum.
  - unit-multiple constants: DOT_U=1, DASH_U=3, ELEM_GAP_U=1, CHAR_GAP_U=3, WORD_GAP_U=7.
- Sub-module morse_sym_fifo: 11-bit wide, FIFO_DEPTH deep, synchronous push/pop, clear input, count output.
- The sequencer FSM and counters stay in morse_tx_sequencer.

Test Plan:
All scenarios use UNIT_CYCLES=4.
- Push "A" (in_code=10'b0110000000, word_end=0) at edge 0 -> key_out high cycles 1-4, low 5-8, high 9-20, low 21-32, busy falls after cycle 32.
- Push "E" (0100000000, word_end=1) then "T" (1000000000) back-to-back -> E mark 4 cycles, 28 low (word gap), 1 idle cycle, T mark 12 cycles.
- Push 5 symbols with the sequencer stalled on a long "0" (1010101010) -> fifo_count reaches 4, in_ready=0, the 5th is not accepted until the first pop, order preserved.
- Push empty code with word_end=0, then with word_end=1 -> first: key_out stays 0, busy 1 cycle. Second: key_out 0 for 28 cycles with busy=1.
- Assert flush during the dash of "A" with 2 queued -> next edge key_out=0, fifo_count=0, busy=0. A push in the same cycle as flush is not stored.
- Drive reset=0 asynchronously mid-mark (between clock edges) -> key_out=0 immediately. After release, in_ready=1 and fifo_count=0.
